// File: rtl/apb_ic_sched.sv
// apb_ic_sched -- transaction scheduler for the shared APB slave bus.
//
// Picks one of NUM_MASTERS core-side requesters round-robin and sequences
// SETUP/ACCESS on the single slave-side bus. A COOL cycle after each
// completion absorbs the master's PSEL deassert latency. Completion
// (s_pready) and error (s_pslverr) strobes go back to the current owner.
//
// Optional feature macro: APB_IC_TIMEOUT_EN
//   When defined, an ACCESS phase that lasts TIMEOUT_CYCLES cycles without
//   xfer_done is force-completed with s_pready and s_pslverr to the owner.
//   When undefined, no counter is built and s_pslverr is tied to 0.
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   asynchronous, active-high
//   reqs         in   [NUM_MASTERS] master PSEL levels
//   xfer_done    in   PREADY of the decoded slave
//   grants       out  [NUM_MASTERS] one-hot owner, registered
//   granted_int  out  [GI_BITS] binary index of grants, registered
//   m_psel_en    out  enables the decoded slave PSEL (SETUP or ACCESS)
//   m_penable    out  slave-side PENABLE (ACCESS)
//   s_pready     out  [NUM_MASTERS] completion strobe to the owner
//   s_pslverr    out  [NUM_MASTERS] error strobe to the owner
//   busy         out  high in SETUP or ACCESS
module apb_ic_sched #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int GI_BITS       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] reqs,
  input  logic                   xfer_done,
  output logic [NUM_MASTERS-1:0] grants,
  output logic [GI_BITS-1:0]     granted_int,
  output logic                   m_psel_en,
  output logic                   m_penable,
  output logic [NUM_MASTERS-1:0] s_pready,
  output logic [NUM_MASTERS-1:0] s_pslverr,
  output logic                   busy
);

  // Reject illegal parameterisations at elaboration time.
  if (NUM_MASTERS < 1) begin : g_bad_num_masters
    $error("apb_ic_sched: NUM_MASTERS must be >= 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("apb_ic_sched: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    COOL   = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [NUM_MASTERS-1:0]   grants_q, grants_d;
  logic [GI_BITS-1:0]       granted_int_q, granted_int_d;
  logic [GI_BITS-1:0]       rr_pick;
  logic                     rr_found;
  logic [GI_BITS-1:0]       rr_cand;
  logic                     owner_req;
  logic                     timeout_hit;

  assign owner_req = reqs[granted_int_q];

  // Round-robin search: the first requester strictly after the last owner,
  // wrapping, so the previous owner has the lowest priority next time.
  always_comb begin
    rr_pick  = granted_int_q;
    rr_found = 1'b0;
    rr_cand  = granted_int_q;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      rr_cand = GI_BITS'((int'(granted_int_q) + i) % NUM_MASTERS);
      if (!rr_found && reqs[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

`ifdef APB_IC_TIMEOUT_EN
  localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES);

  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  // An abort (owner dropped PSEL) takes precedence so no strobe reaches a
  // master that has already given up; xfer_done always wins over timeout.
  assign timeout_hit = (state_q == ACCESS) && !xfer_done && owner_req &&
                       (cnt_q == CNT_BITS'(TIMEOUT_CYCLES - 1));

  // Cleared while in SETUP so every ACCESS phase starts counting from 0.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = '0;
    end else if (state_q == ACCESS && !xfer_done) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and grant update. Arbitration happens only in IDLE, so the
  // grant is stable for the whole transfer and through COOL.
  always_comb begin
    state_d       = state_q;
    grants_d      = grants_q;
    granted_int_d = granted_int_q;
    unique case (state_q)
      IDLE: begin
        if (rr_found) begin
          grants_d      = NUM_MASTERS'(1) << rr_pick;
          granted_int_d = rr_pick;
          state_d       = SETUP;
        end
      end
      SETUP: begin
        state_d = owner_req ? ACCESS : IDLE;
      end
      ACCESS: begin
        if (xfer_done) begin
          state_d = COOL;
        end else if (!owner_req) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d = COOL;
        end
      end
      COOL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset leaves the last master as owner so the search picks master 0 first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grants_q      <= NUM_MASTERS'(1) << (NUM_MASTERS - 1);
      granted_int_q <= GI_BITS'(NUM_MASTERS - 1);
    end else begin
      state_q       <= state_d;
      grants_q      <= grants_d;
      granted_int_q <= granted_int_d;
    end
  end

  assign grants      = grants_q;
  assign granted_int = granted_int_q;
  assign m_psel_en   = (state_q == SETUP) || (state_q == ACCESS);
  assign m_penable   = (state_q == ACCESS);
  assign busy        = m_psel_en;
  assign s_pready    = ((state_q == ACCESS) && (xfer_done || timeout_hit)) ? grants_q : '0;
  assign s_pslverr   = timeout_hit ? grants_q : '0;

endmodule

// File: tb/tb_apb_ic_sched.sv
// tb_apb_ic_sched -- self-checking bench for apb_ic_sched (4 masters).
// Directed table vectors, hand-written multi-cycle sequences and a random
// run compared against a transaction-level model of the scheduler.
module tb_apb_ic_sched;

  localparam int N = 4;
`ifdef APB_IC_TIMEOUT_EN
  localparam int TOC   = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TOC   = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] reqs;
  logic         xfer_done;
  logic [N-1:0] grants;
  logic [1:0]   granted_int;
  logic         m_psel_en;
  logic         m_penable;
  logic [N-1:0] s_pready;
  logic [N-1:0] s_pslverr;
  logic         busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  apb_ic_sched #(
    .NUM_MASTERS(N),
    .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .reqs(reqs),
    .xfer_done(xfer_done),
    .grants(grants),
    .granted_int(granted_int),
    .m_psel_en(m_psel_en),
    .m_penable(m_penable),
    .s_pready(s_pready),
    .s_pslverr(s_pslverr),
    .busy(busy)
  );

  // Reference model: phase 0 idle, 1 address phase, 2 data phase, 3 cool.
  int m_phase;
  int m_owner;
  int m_cnt;

  task automatic m_reset();
    m_phase = 0;
    m_owner = N - 1;
    m_cnt   = 0;
  endtask

  function automatic bit m_timeout(input logic [N-1:0] r, input logic x);
    return TO_EN && (m_phase == 2) && !x && r[2'(m_owner)] && (m_cnt == TOC - 1);
  endfunction

  function automatic logic [16:0] m_expect(input logic [N-1:0] r, input logic x);
    logic [N-1:0] g;
    logic [N-1:0] pr;
    logic [N-1:0] pe;
    bit act;
    bit to;
    g   = 4'(1) << m_owner;
    act = (m_phase == 1) || (m_phase == 2);
    to  = m_timeout(r, x);
    pr  = ((m_phase == 2) && (x || to)) ? g : 4'b0;
    pe  = to ? g : 4'b0;
    return {g, 2'(m_owner), act, (m_phase == 2), pr, pe, act};
  endfunction

  task automatic m_step(input logic [N-1:0] r, input logic x);
    bit to;
    to = m_timeout(r, x);
    case (m_phase)
      0: begin
        for (int k = 1; k <= N; k++) begin
          if (r[2'((m_owner + k) % N)]) begin
            m_owner = (m_owner + k) % N;
            m_phase = 1;
            break;
          end
        end
      end
      1: begin
        m_phase = r[2'(m_owner)] ? 2 : 0;
        m_cnt   = 0;
      end
      2: begin
        if (x) m_phase = 3;
        else if (!r[2'(m_owner)]) m_phase = 0;
        else if (to) m_phase = 3;
        else m_cnt = m_cnt + 1;
      end
      default: m_phase = 0;
    endcase
  endtask

  function automatic logic [16:0] dut_pack();
    return {grants, granted_int, m_psel_en, m_penable, s_pready, s_pslverr, busy};
  endfunction

  // One cycle: drive inputs on the falling edge, sample outputs 1 time unit later.
  task automatic applyStimulus(input logic [N-1:0] r, input logic x);
    @(negedge clk);
    reqs      = r;
    xfer_done = x;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset     = 1'b1;
    reqs      = '0;
    xfer_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
  endtask

  typedef struct {
    logic [N-1:0] reqs;
    logic         xd;
    logic [N-1:0] grants;
    logic         psel;
    logic         pen;
    logic [N-1:0] pready;
    logic         busy;
  } vec_t;

  vec_t vecs[6];

  // Safety net in case the run stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [N-1:0] rnd_reqs;
    logic         rnd_xd;

    reset     = 1'b1;
    reqs      = '0;
    xfer_done = 1'b0;
    m_reset();

    // Single master 0 transfer; xfer_done high outside ACCESS must be ignored.
    vecs[0] = '{4'b0001, 1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[1] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, 1'b1};
    vecs[2] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1};
    vecs[3] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[4] = '{4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[5] = '{4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0};

    doReset();
    checkOutput("reset granted_int", 32'(granted_int), 32'd3);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].reqs, vecs[i].xd);
      checkOutput($sformatf("vec%0d grants", i), 32'(grants), 32'(vecs[i].grants));
      checkOutput($sformatf("vec%0d psel", i), 32'(m_psel_en), 32'(vecs[i].psel));
      checkOutput($sformatf("vec%0d penable", i), 32'(m_penable), 32'(vecs[i].pen));
      checkOutput($sformatf("vec%0d pready", i), 32'(s_pready), 32'(vecs[i].pready));
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
    end

    // All masters requesting: grants rotate 0,1,2,3,0 with 4-cycle spacing.
    doReset();
    for (int c = 0; c < 18; c++) begin
      applyStimulus(4'b1111, 1'b1);
      checkOutput($sformatf("rr setup c%0d", c), 32'(m_psel_en & ~m_penable), 32'(c % 4 == 1));
      if (c % 4 == 1) begin
        checkOutput($sformatf("rr grant c%0d", c), 32'(grants), 32'(4'(1) << (((c - 1) / 4) % 4)));
      end
    end

    // Master 2 alone is re-granted after COOL, no grant change in COOL.
    doReset();
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("m2 first grant", 32'(grants), 32'h4);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("m2 pready", 32'(s_pready), 32'h4);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("m2 cool busy", 32'(busy), 32'h0);
    checkOutput("m2 cool grants", 32'(grants), 32'h4);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("m2 idle busy", 32'(busy), 32'h0);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("m2 regrant", 32'(grants), 32'h4);
    checkOutput("m2 regrant psel", 32'(m_psel_en), 32'h1);

    // Master 1 drops its request in ACCESS: abort with no strobe.
    doReset();
    applyStimulus(4'b0010, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("abort grant", 32'(grants), 32'h2);
    applyStimulus(4'b0010, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("abort access pready", 32'(s_pready), 32'h0);
    checkOutput("abort access pslverr", 32'(s_pslverr), 32'h0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("abort idle busy", 32'(busy), 32'h0);
    checkOutput("abort idle pready", 32'(s_pready), 32'h0);

    // Reset asserted in ACCESS: outputs return to reset values at once.
    doReset();
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("pre-reset penable", 32'(m_penable), 32'h1);
    #2;
    reset     = 1'b1;
    xfer_done = 1'b1;
    #1;
    checkOutput("midreset grants", 32'(grants), 32'h8);
    checkOutput("midreset granted_int", 32'(granted_int), 32'h3);
    checkOutput("midreset busy", 32'(busy), 32'h0);
    checkOutput("midreset pready", 32'(s_pready), 32'h0);
    @(negedge clk);
    reset     = 1'b0;
    reqs      = '0;
    xfer_done = 1'b0;
    applyStimulus(4'b1111, 1'b0);
    checkOutput("postreset idle", 32'(busy), 32'h0);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("postreset first grant", 32'(grants), 32'h1);

`ifdef APB_IC_TIMEOUT_EN
    // Timeout on the 8th ACCESS cycle; then xfer_done on that cycle wins.
    for (int pass = 0; pass < 2; pass++) begin
      doReset();
      applyStimulus(4'b0001, 1'b0);
      applyStimulus(4'b0001, 1'b0);
      for (int k = 1; k <= TOC; k++) begin
        applyStimulus(4'b0001, (pass == 1) && (k == TOC));
        checkOutput($sformatf("to p%0d k%0d pready", pass, k), 32'(s_pready),
                    (k == TOC) ? 32'h1 : 32'h0);
        checkOutput($sformatf("to p%0d k%0d pslverr", pass, k), 32'(s_pslverr),
                    ((k == TOC) && (pass == 0)) ? 32'h1 : 32'h0);
      end
      applyStimulus(4'b0001, 1'b0);
      checkOutput($sformatf("to p%0d cool penable", pass), 32'(m_penable), 32'h0);
    end
`endif

    // Random run against the reference model.
    doReset();
    rnd_reqs = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) rnd_reqs = 4'($urandom_range(0, 15));
      rnd_xd = ($urandom_range(0, 2) == 0);
      applyStimulus(rnd_reqs, rnd_xd);
      checkOutput($sformatf("rand c%0d", c), 32'(dut_pack()), 32'(m_expect(rnd_reqs, rnd_xd)));
      m_step(rnd_reqs, rnd_xd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
